// File: rtl/dsp_config_loader.sv
// dsp_config_loader
// Feeds the DSP slice's serial configuration chain. Words arrive over a
// valid/ready handshake and are shifted out LSB-first, one bit per cycle,
// qualified by configuration_enable, until CHAIN_LEN bits have been sent.
// Upper bits of a final partial word are dropped. A one-cycle done pulse
// marks a completed load. All outputs are registered, so nothing on the
// input side can reach an output combinationally.
module dsp_config_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              configuration_input,
    output logic              configuration_enable,
    output logic              busy,
    output logic              done
);

    localparam int CW  = $clog2(CHAIN_LEN + 1);
    localparam int WLW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] sreg, sreg_n;
    logic [CW-1:0]     bits_done, bits_n;
    logic [WLW-1:0]    word_left, wl_n;
    logic [31:0]       remain;

    // Next-state and datapath update; abort overrides every other event.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        bits_n  = bits_done;
        wl_n    = word_left;
        remain  = 32'(CHAIN_LEN) - 32'(bits_done);
        case (state)
            IDLE: begin
                bits_n = '0;
                wl_n   = '0;
                if (start && !abort) state_n = LOAD;
            end
            LOAD: begin
                if (s_valid) begin
                    sreg_n  = s_data;
                    // Last word may be partial: only the bits the chain still needs.
                    wl_n    = (remain < 32'(WORD_W)) ? WLW'(remain) : WLW'(WORD_W);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sreg_n = sreg >> 1;
                bits_n = bits_done + CW'(1);
                wl_n   = word_left - WLW'(1);
                if (bits_done == CW'(CHAIN_LEN - 1)) state_n = DONE;
                else if (word_left == WLW'(1))       state_n = LOAD;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            bits_n  = '0;
            wl_n    = '0;
        end
    end

    // State, datapath and registered output decode of the upcoming state.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state                <= IDLE;
            sreg                 <= '0;
            bits_done            <= '0;
            word_left            <= '0;
            s_ready              <= 1'b0;
            configuration_input  <= 1'b0;
            configuration_enable <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            state                <= state_n;
            sreg                 <= sreg_n;
            bits_done            <= bits_n;
            word_left            <= wl_n;
            s_ready              <= (state_n == LOAD);
            configuration_enable <= (state_n == SHIFT);
            configuration_input  <= (state_n == SHIFT) && sreg_n[0];
            busy                 <= (state_n != IDLE);
            done                 <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_dsp_config_loader.sv
// Bench for dsp_config_loader: directed loads on a default instance and a
// CHAIN_LEN=1/WORD_W=1 instance. Stimulus pushes expected serial bits, done
// cycles and output snapshots into queues; a negedge monitor pops and compares.
module tb_dsp_config_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       RSTN, start, abort, s_valid;
    logic [7:0] s_data;
    logic       s_ready, cin, cen, busy, done;

    logic       start1, s_valid1;
    logic [0:0] s_data1;
    logic       s_ready1, cin1, cen1, busy1, done1;
    logic       abort1;

    dsp_config_loader dut0 (
        .clk(clk), .RSTN(RSTN), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .configuration_input(cin), .configuration_enable(cen),
        .busy(busy), .done(done)
    );

    dsp_config_loader #(.CHAIN_LEN(1), .WORD_W(1)) dut1 (
        .clk(clk), .RSTN(RSTN), .start(start1), .abort(abort1),
        .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .configuration_input(cin1), .configuration_enable(cen1),
        .busy(busy1), .done(done1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; logic b; }              bit_t;
    typedef struct { int id; int c; }                done_t;
    typedef struct { int id; int c; logic [4:0] v; } probe_t;

    bit_t   bitq[$];
    done_t  doneq[$];
    probe_t probeq[$];

    int checks = 0;
    int errors = 0;
    bit stim_done = 1'b0;

    // Hand-computed serial stream for words A5, 3C, F9 with CHAIN_LEN=20.
    logic ref_bits [20] = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,1};

    // {s_ready, enable, input, busy, done}
    function automatic logic [4:0] snap(input int id);
        if (id == 0) return {s_ready, cen, cin, busy, done};
        return {s_ready1, cen1, cin1, busy1, done1};
    endfunction

    // Monitor: all comparisons and the summary live here.
    probe_t     p;
    bit_t       eb;
    done_t      ed;
    logic [4:0] got;
    int         en_cnt [2];
    always @(negedge clk) begin
        while (probeq.size() > 0 && probeq[0].c <= cyc) begin
            p = probeq.pop_front();
            got = snap(p.id);
            checks++;
            if (p.c != cyc || got !== p.v) begin
                errors++;
                $display("FAIL probe dut%0d cyc %0d (seen cyc %0d): got %b want %b", p.id, p.c, cyc, got, p.v);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if ((k == 0 ? busy : busy1) !== 1'b1) en_cnt[k] = 0;
            if ((k == 0 ? cen : cen1) === 1'b1) begin
                en_cnt[k]++;
                checks++;
                if (bitq.size() == 0 || bitq[0].id != k) begin
                    errors++;
                    $display("FAIL extra_enable dut%0d cyc %0d: got enable=1 want no enable", k, cyc);
                end else begin
                    eb = bitq.pop_front();
                    if ((k == 0 ? cin : cin1) !== eb.b) begin
                        errors++;
                        $display("FAIL serial_bit dut%0d cyc %0d: got %b want %b", k, cyc, (k == 0 ? cin : cin1), eb.b);
                    end
                end
            end
            if ((k == 0 ? done : done1) === 1'b1) begin
                checks++;
                if (doneq.size() == 0 || doneq[0].id != k) begin
                    errors++;
                    $display("FAIL unexpected_done dut%0d cyc %0d: got done=1 want 0", k, cyc);
                end else begin
                    ed = doneq.pop_front();
                    if (ed.c != cyc) begin
                        errors++;
                        $display("FAIL done_cycle dut%0d: got %0d want %0d", k, cyc, ed.c);
                    end
                end
                checks++;
                if (en_cnt[k] != (k == 0 ? 20 : 1)) begin
                    errors++;
                    $display("FAIL enable_count dut%0d: got %0d want %0d", k, en_cnt[k], (k == 0 ? 20 : 1));
                end
            end
        end
        if (stim_done || cyc > 4000) begin
            checks++;
            if (!stim_done || bitq.size() != 0 || doneq.size() != 0 || probeq.size() != 0) begin
                errors++;
                $display("FAIL leftover: got bits=%0d dones=%0d probes=%0d timeout=%0d want all 0",
                         bitq.size(), doneq.size(), probeq.size(), !stim_done);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_probe(input int id, input int c, input logic [4:0] v);
        probe_t e;
        e.id = id; e.c = c; e.v = v;
        probeq.push_back(e);
    endtask

    task automatic push_bits(input int n);
        bit_t e;
        for (int i = 0; i < n; i++) begin
            e.id = 0; e.b = ref_bits[i];
            bitq.push_back(e);
        end
    endtask

    task automatic push_done(input int id, input int c);
        done_t e;
        e.id = id; e.c = c;
        doneq.push_back(e);
    endtask

    // Drives one load on dut0 from a 3-word source; start at relative cycle 0.
    task automatic run_load(input int stall_at, input int stall_n, input int abort_at,
                            input int rst_at, input int xstart_at, input int ncyc);
        logic [7:0] w [3];
        int idx;
        bit hs;
        w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'hF9;
        idx = 0;
        for (int r = 0; r < ncyc; r++) begin
            start   = (r == 0) || (r == xstart_at);
            abort   = (r == abort_at);
            s_valid = !(r >= stall_at && r < stall_at + stall_n) && idx < 3;
            s_data  = w[idx < 3 ? idx : 2];
            if (r == rst_at) RSTN = 1'b0;
            @(negedge clk);
            hs = s_valid && s_ready;
            tick(1);
            if (hs) idx++;
        end
        start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    endtask

    task automatic ref_load(input int xstart_at);
        int t0;
        t0 = cyc;
        push_bits(20);
        push_done(0, t0 + 24);
        push_probe(0, t0,      5'b00000);
        push_probe(0, t0 + 1,  5'b10010);
        push_probe(0, t0 + 2,  5'b01110);
        push_probe(0, t0 + 9,  5'b01110);
        push_probe(0, t0 + 10, 5'b10010);
        push_probe(0, t0 + 19, 5'b10010);
        push_probe(0, t0 + 23, 5'b01110);
        push_probe(0, t0 + 24, 5'b00011);
        push_probe(0, t0 + 25, 5'b00000);
        run_load(0, 0, -1, -1, xstart_at, 26);
    endtask

    initial begin
        int t0;
        RSTN = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        start1 = 1'b0; s_valid1 = 1'b0; s_data1 = '0; abort1 = 1'b0;
        tick(3);
        push_probe(0, cyc, 5'b00000);
        push_probe(1, cyc, 5'b00000);
        tick(1);
        RSTN = 1'b1;
        tick(2);

        // Reference load
        ref_load(-1);
        tick(2);

        // Stalled source before the second word
        t0 = cyc;
        push_bits(20);
        push_done(0, t0 + 29);
        push_probe(0, t0 + 12, 5'b10010);
        push_probe(0, t0 + 15, 5'b10010);
        push_probe(0, t0 + 16, 5'b01010);
        push_probe(0, t0 + 28, 5'b01110);
        push_probe(0, t0 + 29, 5'b00011);
        run_load(10, 5, -1, -1, -1, 31);
        tick(2);

        // Abort at relative cycle 6, then a full load
        t0 = cyc;
        push_bits(5);
        push_probe(0, t0 + 6, 5'b01010);
        push_probe(0, t0 + 7, 5'b00000);
        run_load(0, 0, 6, -1, -1, 10);
        tick(2);
        ref_load(-1);
        tick(2);

        // Asynchronous reset at relative cycle 12, then a full load
        t0 = cyc;
        push_bits(9);
        push_probe(0, t0 + 11, 5'b01010);
        push_probe(0, t0 + 12, 5'b00000);
        push_probe(1, t0 + 12, 5'b00000);
        run_load(0, 0, -1, 12, -1, 14);
        RSTN = 1'b1;
        tick(2);
        ref_load(-1);
        tick(2);

        // start pulsed during SHIFT is ignored
        ref_load(5);
        tick(2);

        // Degenerate instance: CHAIN_LEN=1, WORD_W=1
        t0 = cyc;
        begin
            bit_t e;
            e.id = 1; e.b = 1'b1;
            bitq.push_back(e);
        end
        push_done(1, t0 + 3);
        push_probe(1, t0 + 1, 5'b10010);
        push_probe(1, t0 + 2, 5'b01110);
        push_probe(1, t0 + 3, 5'b00011);
        push_probe(1, t0 + 4, 5'b00000);
        start1 = 1'b1; s_valid1 = 1'b1; s_data1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        tick(5);
        s_valid1 = 1'b0;
        tick(2);

        stim_done = 1'b1;
    end

endmodule
